// File: rtl/axi_4_lite_cfg_seq_pkg.sv
// Shared AXI4-Lite configuration definitions: response codes, error codes, sequencer states.
package axi_4_lite_cfg_seq_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RESP    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_VERIFY  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

endpackage

// File: rtl/axi_4_lite_cfg_seq_if.sv
// AXI4-Lite bus between the configuration sequencer (master) and the register-file slave.
interface axi_4_lite_cfg_seq_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic                  M_AXI_AWVALID;
  logic                  M_AXI_AWREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_AWADDR;
  logic [2:0]            M_AXI_AWPROT;
  logic                  M_AXI_WVALID;
  logic                  M_AXI_WREADY;
  logic [DATA_WIDTH-1:0] M_AXI_WDATA;
  logic [STRB_W-1:0]     M_AXI_WSTRB;
  logic                  M_AXI_BVALID;
  logic                  M_AXI_BREADY;
  logic [1:0]            M_AXI_BRESP;
  logic                  M_AXI_ARVALID;
  logic                  M_AXI_ARREADY;
  logic [ADDR_WIDTH-1:0] M_AXI_ARADDR;
  logic [2:0]            M_AXI_ARPROT;
  logic                  M_AXI_RVALID;
  logic                  M_AXI_RREADY;
  logic [DATA_WIDTH-1:0] M_AXI_RDATA;
  logic [1:0]            M_AXI_RRESP;

  modport master (
    output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    output M_AXI_BREADY,
    output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    output M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );

  modport slave (
    input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
    input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
    input  M_AXI_BREADY,
    input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
    input  M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_BRESP,
    output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP
  );

endinterface

// File: rtl/axi_4_lite_cfg_rom.sv
// Parameter-defined command table: combinational lookup of (addr, data, strobe) by index.
module axi_4_lite_cfg_rom #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CMDS   = 8,
  parameter int unsigned IDX_BITS   = 3,
  parameter logic [NUM_CMDS-1:0][ADDR_WIDTH-1:0]   CMD_ADDR = '0,
  parameter logic [NUM_CMDS-1:0][DATA_WIDTH-1:0]   CMD_DATA = '0,
  parameter logic [NUM_CMDS-1:0][DATA_WIDTH/8-1:0] CMD_STRB = '1
) (
  input  logic [IDX_BITS-1:0]     idx_i,
  output logic [ADDR_WIDTH-1:0]   addr_c_o,
  output logic [DATA_WIDTH-1:0]   data_c_o,
  output logic [DATA_WIDTH/8-1:0] strb_c_o
);

  // Compare-and-select mux; indices past the table return an all-zero entry
  always_comb begin
    addr_c_o = '0;
    data_c_o = '0;
    strb_c_o = '0;
    for (int i = 0; i < int'(NUM_CMDS); i++) begin
      if (idx_i == IDX_BITS'(i)) begin
        addr_c_o = CMD_ADDR[i];
        data_c_o = CMD_DATA[i];
        strb_c_o = CMD_STRB[i];
      end
    end
  end

endmodule

// File: rtl/axi_4_lite_cfg_seq.sv
// AXI4-Lite configuration sequencer: walks the command table issuing single-beat writes.
// Optional readback check of every entry is compiled in with `define AXI_CFG_SEQ_VERIFY_EN.
module axi_4_lite_cfg_seq
  import axi_4_lite_cfg_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_CMDS       = 8,
  parameter int unsigned IDX_BITS       = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [NUM_CMDS-1:0][ADDR_WIDTH-1:0]   CMD_ADDR = '0,
  parameter logic [NUM_CMDS-1:0][DATA_WIDTH-1:0]   CMD_DATA = '0,
  parameter logic [NUM_CMDS-1:0][DATA_WIDTH/8-1:0] CMD_STRB = '1
) (
  input  logic                M_AXI_ACLK,
  input  logic                M_AXI_ARESET,
  input  logic                START,
  output logic                BUSY,
  output logic                DONE,
  output logic                ERROR,
  output logic [IDX_BITS-1:0] ERR_IDX,
  output logic [1:0]          ERR_CODE,
  axi_4_lite_cfg_seq_if.master m_axi
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

  state_e                state_q, state_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [IDX_BITS-1:0]   err_idx_q, err_idx_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;

  logic [ADDR_WIDTH-1:0] rom_addr_c;
  logic [DATA_WIDTH-1:0] rom_data_c;
  logic [STRB_W-1:0]     rom_strb_c;
  logic [WDOG_W-1:0]     wdog_inc_c;
  logic                  wdog_exp_c;
  logic                  aw_hs_c, w_hs_c, b_hs_c;

  axi_4_lite_cfg_rom #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CMDS   (NUM_CMDS),
    .IDX_BITS   (IDX_BITS),
    .CMD_ADDR   (CMD_ADDR),
    .CMD_DATA   (CMD_DATA),
    .CMD_STRB   (CMD_STRB)
  ) u_rom (
    .idx_i    (idx_q),
    .addr_c_o (rom_addr_c),
    .data_c_o (rom_data_c),
    .strb_c_o (rom_strb_c)
  );

  assign aw_hs_c    = awvalid_q & m_axi.M_AXI_AWREADY;
  assign w_hs_c     = wvalid_q & m_axi.M_AXI_WREADY;
  assign b_hs_c     = bready_q & m_axi.M_AXI_BVALID;
  assign wdog_inc_c = wdog_q + WDOG_W'(1);
  assign wdog_exp_c = (wdog_inc_c >= WDOG_W'(TIMEOUT_CYCLES));

`ifdef AXI_CFG_SEQ_VERIFY_EN
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  ar_hs_c, r_hs_c, rd_mismatch_c;
  logic [DATA_WIDTH-1:0] lane_mask_c;

  assign ar_hs_c = arvalid_q & m_axi.M_AXI_ARREADY;
  assign r_hs_c  = rready_q & m_axi.M_AXI_RVALID;

  // Expand the entry strobe to a bit mask so unstrobed bytes never flag a mismatch
  always_comb begin
    lane_mask_c = '0;
    for (int b = 0; b < int'(STRB_W); b++) begin
      lane_mask_c[b*8 +: 8] = {8{strb_q[b]}};
    end
  end

  assign rd_mismatch_c        = |((m_axi.M_AXI_RDATA ^ data_q) & lane_mask_c);
  assign m_axi.M_AXI_ARVALID  = arvalid_q;
  assign m_axi.M_AXI_ARADDR   = addr_q;
  assign m_axi.M_AXI_RREADY   = rready_q;
`else
  assign m_axi.M_AXI_ARVALID  = 1'b0;
  assign m_axi.M_AXI_ARADDR   = '0;
  assign m_axi.M_AXI_RREADY   = 1'b0;
`endif

  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_AWADDR  = addr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_WDATA   = data_q;
  assign m_axi.M_AXI_WSTRB   = strb_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign BUSY                = busy_q;
  assign DONE                = done_q;
  assign ERROR               = error_q;
  assign ERR_IDX             = err_idx_q;
  assign ERR_CODE            = err_code_q;

  // State and output registers with synchronous reset
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_idx_q  <= '0;
      err_code_q <= ERR_NONE;
      wdog_q     <= '0;
`ifdef AXI_CFG_SEQ_VERIFY_EN
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_idx_q  <= err_idx_d;
      err_code_q <= err_code_d;
      wdog_q     <= wdog_d;
`ifdef AXI_CFG_SEQ_VERIFY_EN
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    err_idx_d  = err_idx_q;
    err_code_d = err_code_q;
    wdog_d     = wdog_q;
`ifdef AXI_CFG_SEQ_VERIFY_EN
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d    = ST_LOAD;
          idx_d      = '0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          busy_d     = 1'b1;
        end
      end
      ST_LOAD: begin
        addr_d    = rom_addr_c;
        data_d    = rom_data_c;
        strb_d    = rom_strb_c;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        bready_d  = 1'b1;
        wdog_d    = '0;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        if (aw_hs_c) awvalid_d = 1'b0;
        if (w_hs_c)  wvalid_d  = 1'b0;
        if (b_hs_c) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          bready_d  = 1'b0;
          if (m_axi.M_AXI_BRESP == RESP_OKAY) begin
`ifdef AXI_CFG_SEQ_VERIFY_EN
            arvalid_d = 1'b1;
            wdog_d    = '0;
            state_d   = ST_VERIFY;
`else
            state_d   = ST_NEXT;
`endif
          end else begin
            err_code_d = ERR_RESP;
            state_d    = ST_ERROR;
          end
        end else if (!aw_hs_c && !w_hs_c && wdog_exp_c) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_ERROR;
        end else begin
          wdog_d = wdog_inc_c;
        end
      end
`ifdef AXI_CFG_SEQ_VERIFY_EN
      ST_VERIFY: begin
        if (ar_hs_c) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
        if (r_hs_c) begin
          rready_d = 1'b0;
          if (m_axi.M_AXI_RRESP != RESP_OKAY) begin
            err_code_d = ERR_RESP;
            state_d    = ST_ERROR;
          end else if (rd_mismatch_c) begin
            err_code_d = ERR_VERIFY;
            state_d    = ST_ERROR;
          end else begin
            state_d = ST_NEXT;
          end
        end else if (!ar_hs_c && wdog_exp_c) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_ERROR;
        end else begin
          wdog_d = wdog_inc_c;
        end
      end
`endif
      ST_NEXT: begin
        if (idx_q == IDX_BITS'(NUM_CMDS - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_BITS'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Entry into ERROR: latch status and release the bus
    if (state_d == ST_ERROR) begin
      error_d   = 1'b1;
      err_idx_d = idx_q;
      busy_d    = 1'b0;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
`ifdef AXI_CFG_SEQ_VERIFY_EN
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_axi_4_lite_cfg_seq.sv
// Bench for axi_4_lite_cfg_seq: three-entry table against a small register-file slave model.
module tb_axi_4_lite_cfg_seq;
  import axi_4_lite_cfg_seq_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned NC = 3;
  localparam int unsigned IB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, error;
  logic [IB-1:0] err_idx;
  logic [1:0]    err_code;

  axi_4_lite_cfg_seq_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_4_lite_cfg_seq #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .NUM_CMDS       (NC),
    .IDX_BITS       (IB),
    .TIMEOUT_CYCLES (255),
    .CMD_ADDR       ({32'h0000_000C, 32'h0000_0004, 32'h0000_0000}),
    .CMD_DATA       ({32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_BEEF}),
    .CMD_STRB       ({4'b1111, 4'b0011, 4'b1111})
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .START        (start),
    .BUSY         (busy),
    .DONE         (done),
    .ERROR        (error),
    .ERR_IDX      (err_idx),
    .ERR_CODE     (err_code),
    .m_axi        (bus)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  bit          hold_aw = 1'b0;
  int          bresp_err_idx = -1;
  logic [1:0]  bresp_val = RESP_SLVERR;
  logic [31:0] rd_xor [8];
  logic [31:0] regs [8];
  logic [31:0] wr_log [8];
  int          wr_issued;
  logic        aw_got, w_got, s_bvalid, ar_got, s_rvalid;
  logic [31:0] aw_addr, w_data, ar_addr, s_rdata;
  logic [3:0]  w_strb;
  logic [1:0]  s_bresp;

  assign bus.M_AXI_AWREADY = !hold_aw && !aw_got && !s_bvalid;
  assign bus.M_AXI_WREADY  = !w_got && !s_bvalid;
  assign bus.M_AXI_BVALID  = s_bvalid;
  assign bus.M_AXI_BRESP   = s_bresp;
  assign bus.M_AXI_ARREADY = !ar_got && !s_rvalid;
  assign bus.M_AXI_RVALID  = s_rvalid;
  assign bus.M_AXI_RDATA   = s_rdata;
  assign bus.M_AXI_RRESP   = RESP_OKAY;

  always @(posedge clk) begin
    if (rst) begin
      aw_got <= 0; w_got <= 0; s_bvalid <= 0; s_bresp <= 0;
      ar_got <= 0; s_rvalid <= 0; s_rdata <= 0; wr_issued <= 0;
      aw_addr <= 0; w_data <= 0; w_strb <= 0; ar_addr <= 0;
      for (int i = 0; i < 8; i++) begin regs[i] <= 0; wr_log[i] <= 0; end
    end else begin
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin aw_got <= 1; aw_addr <= bus.M_AXI_AWADDR; end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        w_got <= 1; w_data <= bus.M_AXI_WDATA; w_strb <= bus.M_AXI_WSTRB;
      end
      if (aw_got && w_got && !s_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (w_strb[b]) regs[aw_addr[4:2]][b*8 +: 8] <= w_data[b*8 +: 8];
        if (wr_issued < 8) wr_log[wr_issued] <= aw_addr;
        s_bresp   <= (wr_issued == bresp_err_idx) ? bresp_val : RESP_OKAY;
        wr_issued <= wr_issued + 1;
        s_bvalid  <= 1; aw_got <= 0; w_got <= 0;
      end
      if (s_bvalid && bus.M_AXI_BREADY) s_bvalid <= 0;
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin ar_got <= 1; ar_addr <= bus.M_AXI_ARADDR; end
      if (ar_got && !s_rvalid) begin
        s_rvalid <= 1; ar_got <= 0;
        s_rdata  <= regs[ar_addr[4:2]] ^ rd_xor[ar_addr[4:2]];
      end
      if (s_rvalid && bus.M_AXI_RREADY) s_rvalid <= 0;
    end
  end

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [31:0] ctl_bits();
    return 32'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY,
                bus.M_AXI_ARVALID, bus.M_AXI_RREADY, busy, done, error});
  endfunction

  typedef struct {
    string       name;
    bit          hold_aw;
    int          berr_idx;
    logic [1:0]  bval;
    int          xor_reg;
    logic [31:0] xor_val;
    bit          exp_done;
    bit          exp_error;
    logic [2:0]  exp_idx;
    logic [1:0]  exp_code;
    int          exp_writes;
  } vec_t;

  task automatic run_vec(input vec_t v);
    bit got_done = 0;
    bit finished = 0;
    do_reset();
    hold_aw = v.hold_aw; bresp_err_idx = v.berr_idx; bresp_val = v.bval;
    for (int i = 0; i < 8; i++) rd_xor[i] = '0;
    if (v.xor_reg >= 0) rd_xor[v.xor_reg] = v.xor_val;
    pulse_start();
    for (int c = 0; c < 2000 && !finished; c++) begin
      @(negedge clk);
      if (done) begin got_done = 1; finished = 1; end
      else if (error) finished = 1;
    end
    check({v.name, "_finished"}, 32'(finished), 32'd1);
    check({v.name, "_done"},     32'(got_done), 32'(v.exp_done));
    check({v.name, "_error"},    32'(error), 32'(v.exp_error));
    check({v.name, "_err_idx"},  32'(err_idx), 32'(v.exp_idx));
    check({v.name, "_err_code"}, 32'(err_code), 32'(v.exp_code));
    check({v.name, "_busy"},     32'(busy), 32'd0);
    check({v.name, "_awvalid"},  32'(bus.M_AXI_AWVALID), 32'd0);
    check({v.name, "_writes"},   32'(wr_issued), 32'(v.exp_writes));
  endtask

  vec_t vecs [8];
  int   n_vec;

  initial begin
    int done_cnt;
    bit seen;
    for (int i = 0; i < 8; i++) rd_xor[i] = '0;

    vecs[0] = '{"normal",     0, -1, RESP_SLVERR, -1, 32'h0,         1, 0, 3'd0, ERR_NONE,    3};
    vecs[1] = '{"slverr_e1",  0,  1, RESP_SLVERR, -1, 32'h0,         0, 1, 3'd1, ERR_RESP,    2};
    vecs[2] = '{"decerr_e0",  0,  0, RESP_DECERR, -1, 32'h0,         0, 1, 3'd0, ERR_RESP,    1};
    vecs[3] = '{"slverr_e2",  0,  2, RESP_SLVERR, -1, 32'h0,         0, 1, 3'd2, ERR_RESP,    3};
    vecs[4] = '{"aw_timeout", 1, -1, RESP_SLVERR, -1, 32'h0,         0, 1, 3'd0, ERR_TIMEOUT, 0};
    n_vec = 5;
`ifdef AXI_CFG_SEQ_VERIFY_EN
    vecs[5] = '{"vfy_byte3",  0, -1, RESP_SLVERR,  0, 32'hFF00_0000, 0, 1, 3'd0, ERR_VERIFY,  1};
    vecs[6] = '{"vfy_unstrb", 0, -1, RESP_SLVERR,  1, 32'hFFFF_0000, 1, 0, 3'd0, ERR_NONE,    3};
    n_vec = 7;
`endif

    // Reset state
    do_reset();
    check("rst_ctl",      ctl_bits(), 32'd0);
    check("rst_err_idx",  32'(err_idx), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_awaddr",   bus.M_AXI_AWADDR, 32'd0);
    check("rst_wdata",    bus.M_AXI_WDATA, 32'd0);
    check("rst_araddr",   bus.M_AXI_ARADDR, 32'd0);

    // Nominal run: order of writes, slave contents, single-cycle DONE
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    done_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        check("busy_in_done", 32'(busy), 32'd0);
      end
    end
    check("nom_done_cnt", 32'(done_cnt), 32'd1);
    check("nom_error",    32'(error), 32'd0);
    check("nom_wr0_addr", wr_log[0], 32'h0000_0000);
    check("nom_wr1_addr", wr_log[1], 32'h0000_0004);
    check("nom_wr2_addr", wr_log[2], 32'h0000_000C);
    check("nom_reg0",     regs[0], 32'hDEAD_BEEF);
    check("nom_reg1",     regs[1], 32'h0000_5678);
    check("nom_reg3",     regs[3], 32'hCAFE_F00D);
    check("nom_prot",     32'({bus.M_AXI_AWPROT, bus.M_AXI_ARPROT}), 32'd0);

    // START while busy must not restart the walk
    do_reset();
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_start();
    done_cnt = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("busy_start_done_cnt", 32'(done_cnt), 32'd1);
    check("busy_start_writes",   32'(wr_issued), 32'd3);

    // Reset in the middle of entry 1's write
    do_reset();
    pulse_start();
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWADDR == 32'h4) seen = 1;
    end
    check("midrst_reached", 32'(seen), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_ctl",   ctl_bits(), 32'd0);
    check("midrst_addr",  bus.M_AXI_AWADDR, 32'd0);
    check("midrst_data",  bus.M_AXI_WDATA, 32'd0);
    check("midrst_strb",  32'(bus.M_AXI_WSTRB), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven scenarios
    for (int i = 0; i < n_vec; i++) run_vec(vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "global timeout");
  end

endmodule
